// File: rtl/qs_srt_pkg.sv
// rtl/qs_srt_pkg.sv - shared types and defaults for the quicksort engine bank scheduler
package qs_srt_pkg;

    localparam int BANKS_N_DEFAULT = 4;

    typedef enum logic [2:0] {
        EMPTY    = 3'd0,
        FILLING  = 3'd1,
        READY    = 3'd2,
        SORTING  = 3'd3,
        SORTED   = 3'd4,
        DRAINING = 3'd5
    } bank_state_t;

    typedef logic [$clog2(BANKS_N_DEFAULT)-1:0] bank_id_t;

endpackage

// File: rtl/qs_bank_sched_ptr.sv
// rtl/qs_bank_sched_ptr.sv - modulo-BANKS_N ring pointer
module qs_bank_sched_ptr #(
    parameter  int BANKS_N = 4,
    localparam int BANK_W  = $clog2(BANKS_N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    output logic [BANK_W-1:0] ptr
);

    // BANKS_N is a power of two, so natural wrap gives the modulo
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + BANK_W'(1);
        end
    end

endmodule

// File: rtl/qs_bank_sched.sv
// rtl/qs_bank_sched.sv - bank lifecycle scheduler between ingress, sort engine and egress
// Optional statistics counters: QS_BANK_SCHED_STATS_EN
module qs_bank_sched
    import qs_srt_pkg::*;
#(
    parameter  int BANKS_N = BANKS_N_DEFAULT,
    localparam int BANK_W  = $clog2(BANKS_N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_alloc_req,
    output logic                 in_alloc_gnt,
    output logic [BANK_W-1:0]    in_bank,
    input  logic                 in_fill_done,
    input  logic                 srt_await,
    output logic                 srt_gnt,
    output logic [BANK_W-1:0]    srt_bank,
    input  logic                 srt_emit,
    output logic                 eg_vld,
    output logic [BANK_W-1:0]    eg_bank,
    input  logic                 eg_rdy,
    input  logic                 eg_done,
    output logic [3*BANKS_N-1:0] bank_state,
    output logic                 err
`ifdef QS_BANK_SCHED_STATS_EN
    ,
    output logic [15:0]          stat_sorts,
    output logic [15:0]          stat_stall
`endif
);

    bank_state_t bank_q [BANKS_N];
    bank_state_t bank_n [BANKS_N];

    logic [BANK_W-1:0] fill_ptr;
    logic [BANK_W-1:0] sort_ptr;
    logic [BANK_W-1:0] drain_ptr;
    logic [BANK_W-1:0] fill_own;
    logic [BANK_W-1:0] sort_sel;
    logic [BANK_W-1:0] drain_sel;

    logic pending_q;
    logic pending_n;
    logic err_n;
    logic fill_ok;
    logic emit_ok;
    logic accept_ok;
    logic drain_ok;
    logic sorting_left;
    logic await_bad;
    logic await_ok;
    logic pend_eff;
    logic sort_grant;
    logic alloc_ok;
    logic eg_vld_n;

    qs_bank_sched_ptr #(.BANKS_N(BANKS_N)) u_fill_ptr (
        .clk (clk),
        .rst (rst),
        .inc (alloc_ok),
        .ptr (fill_ptr)
    );

    qs_bank_sched_ptr #(.BANKS_N(BANKS_N)) u_sort_ptr (
        .clk (clk),
        .rst (rst),
        .inc (emit_ok),
        .ptr (sort_ptr)
    );

    qs_bank_sched_ptr #(.BANKS_N(BANKS_N)) u_drain_ptr (
        .clk (clk),
        .rst (rst),
        .inc (drain_ok),
        .ptr (drain_ptr)
    );

    // Each agent owns at most one bank, always the one at (or just behind) its pointer
    assign fill_own = fill_ptr - BANK_W'(1);

    always_comb begin
        bank_n       = bank_q;
        fill_ok      = in_fill_done && (bank_q[fill_own] == FILLING);
        emit_ok      = srt_emit && (bank_q[sort_ptr] == SORTING);
        accept_ok    = eg_vld && eg_rdy && (bank_q[drain_ptr] == SORTED);
        drain_ok     = eg_done && (bank_q[drain_ptr] == DRAINING);
        alloc_ok     = in_alloc_req && (bank_q[fill_own] != FILLING) &&
                       (bank_q[fill_ptr] == EMPTY);
        sorting_left = (bank_q[sort_ptr] == SORTING) && !emit_ok;
        await_bad    = srt_await && (pending_q || sorting_left);
        await_ok     = srt_await && !await_bad;
        pend_eff     = pending_q || await_ok;
        sort_sel     = emit_ok ? sort_ptr + BANK_W'(1) : sort_ptr;
        drain_sel    = drain_ok ? drain_ptr + BANK_W'(1) : drain_ptr;

        if (fill_ok)   bank_n[fill_own]  = READY;
        if (emit_ok)   bank_n[sort_ptr]  = SORTED;
        if (accept_ok) bank_n[drain_ptr] = DRAINING;
        if (drain_ok)  bank_n[drain_ptr] = EMPTY;
        if (alloc_ok)  bank_n[fill_ptr]  = FILLING;

        // The grant sees this cycle's fill-done and emit, so a waiting await answers one cycle later
        sort_grant = pend_eff && !sorting_left && (bank_n[sort_sel] == READY);
        if (sort_grant) bank_n[sort_sel] = SORTING;

        pending_n = pend_eff && !sort_grant;
        err_n     = err || (in_fill_done && !fill_ok) || (srt_emit && !emit_ok) ||
                    (eg_done && !drain_ok) || await_bad;
        eg_vld_n  = (bank_n[drain_sel] == SORTED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BANKS_N; i++) begin
                bank_q[i] <= EMPTY;
            end
            pending_q    <= 1'b0;
            err          <= 1'b0;
            in_alloc_gnt <= 1'b0;
            in_bank      <= '0;
            srt_gnt      <= 1'b0;
            srt_bank     <= '0;
            eg_vld       <= 1'b0;
        end else begin
            bank_q       <= bank_n;
            pending_q    <= pending_n;
            err          <= err_n;
            in_alloc_gnt <= alloc_ok;
            srt_gnt      <= sort_grant;
            eg_vld       <= eg_vld_n;
            if (alloc_ok) begin
                in_bank <= fill_ptr;
            end
            if (sort_grant) begin
                srt_bank <= sort_sel;
            end
        end
    end

    assign eg_bank = drain_ptr;

    for (genvar g = 0; g < BANKS_N; g++) begin : g_state
        assign bank_state[3*g +: 3] = bank_q[g];
    end

`ifdef QS_BANK_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_sorts <= '0;
            stat_stall <= '0;
        end else begin
            if (emit_ok && (stat_sorts != 16'hffff)) begin
                stat_sorts <= stat_sorts + 16'd1;
            end
            if (pend_eff && !sort_grant && (stat_stall != 16'hffff)) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qs_bank_sched.sv
// tb/tb_qs_bank_sched.sv - self-checking bench for qs_bank_sched with a behavioural ring model
module tb_qs_bank_sched;

    localparam int S_EMPTY    = 0;
    localparam int S_FILLING  = 1;
    localparam int S_READY    = 2;
    localparam int S_SORTING  = 3;
    localparam int S_SORTED   = 4;
    localparam int S_DRAINING = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_alloc_req;
    logic        in_alloc_gnt;
    logic [1:0]  in_bank;
    logic        in_fill_done;
    logic        srt_await;
    logic        srt_gnt;
    logic [1:0]  srt_bank;
    logic        srt_emit;
    logic        eg_vld;
    logic [1:0]  eg_bank;
    logic        eg_rdy;
    logic        eg_done;
    logic [11:0] bank_state;
    logic        err;
`ifdef QS_BANK_SCHED_STATS_EN
    logic [15:0] stat_sorts;
    logic [15:0] stat_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int   m_state [4];
    int   m_fill, m_sort, m_drain;
    bit   m_pending;
    logic e_in_gnt, e_srt_gnt, e_eg_vld, e_err;
    logic [1:0] e_in_bank, e_srt_bank, e_eg_bank;

    qs_bank_sched #(.BANKS_N(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_alloc_req (in_alloc_req),
        .in_alloc_gnt (in_alloc_gnt),
        .in_bank      (in_bank),
        .in_fill_done (in_fill_done),
        .srt_await    (srt_await),
        .srt_gnt      (srt_gnt),
        .srt_bank     (srt_bank),
        .srt_emit     (srt_emit),
        .eg_vld       (eg_vld),
        .eg_bank      (eg_bank),
        .eg_rdy       (eg_rdy),
        .eg_done      (eg_done),
        .bank_state   (bank_state),
        .err          (err)
`ifdef QS_BANK_SCHED_STATS_EN
        ,
        .stat_sorts   (stat_sorts),
        .stat_stall   (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(input int a [4], input int st);
        for (int i = 0; i < 4; i++) begin
            if (a[i] == st) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_state[i] = S_EMPTY;
        m_fill = 0; m_sort = 0; m_drain = 0; m_pending = 0;
        e_in_gnt = 0; e_srt_gnt = 0; e_eg_vld = 0; e_err = 0;
        e_in_bank = 0; e_srt_bank = 0; e_eg_bank = 0;
    endtask

    // Applies one clock of the scheduler rules to the bench's own bank picture
    task automatic model_step();
        int cur [4];
        int filling, sorting, draining;
        bit em_ok, still_sorting;
        e_in_gnt  = 0;
        e_srt_gnt = 0;
        if (rst) begin
            model_reset();
            return;
        end
        cur      = m_state;
        filling  = find(cur, S_FILLING);
        sorting  = find(cur, S_SORTING);
        draining = find(cur, S_DRAINING);
        if (in_fill_done) begin
            if (filling < 0) e_err = 1; else m_state[filling] = S_READY;
        end
        em_ok = 0;
        if (srt_emit) begin
            if (sorting < 0) e_err = 1;
            else begin
                m_state[sorting] = S_SORTED;
                m_sort = (m_sort + 1) % 4;
                em_ok = 1;
            end
        end
        if (eg_rdy && cur[m_drain] == S_SORTED) m_state[m_drain] = S_DRAINING;
        if (eg_done) begin
            if (draining < 0) e_err = 1;
            else begin
                m_state[draining] = S_EMPTY;
                m_drain = (m_drain + 1) % 4;
            end
        end
        still_sorting = (sorting >= 0) && !em_ok;
        if (srt_await) begin
            if (m_pending || still_sorting) e_err = 1; else m_pending = 1;
        end
        if (m_pending && !still_sorting && m_state[m_sort] == S_READY) begin
            m_state[m_sort] = S_SORTING;
            m_pending  = 0;
            e_srt_gnt  = 1;
            e_srt_bank = 2'(m_sort);
        end
        if (in_alloc_req && filling < 0 && cur[m_fill] == S_EMPTY) begin
            m_state[m_fill] = S_FILLING;
            e_in_gnt  = 1;
            e_in_bank = 2'(m_fill);
            m_fill    = (m_fill + 1) % 4;
        end
        e_eg_vld  = (m_state[m_drain] == S_SORTED);
        e_eg_bank = 2'(m_drain);
    endtask

    task automatic check_all();
        logic [11:0] exp_bs;
        for (int i = 0; i < 4; i++) exp_bs[3*i +: 3] = 3'(m_state[i]);
        check("m_in_alloc_gnt", 32'(in_alloc_gnt), 32'(e_in_gnt));
        check("m_in_bank",      32'(in_bank),      32'(e_in_bank));
        check("m_srt_gnt",      32'(srt_gnt),      32'(e_srt_gnt));
        check("m_srt_bank",     32'(srt_bank),     32'(e_srt_bank));
        check("m_eg_vld",       32'(eg_vld),       32'(e_eg_vld));
        check("m_eg_bank",      32'(eg_bank),      32'(e_eg_bank));
        check("m_err",          32'(err),          32'(e_err));
        check("m_bank_state",   32'(bank_state),   32'(exp_bs));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic clr();
        in_alloc_req = 0; in_fill_done = 0; srt_await = 0;
        srt_emit = 0; eg_rdy = 0; eg_done = 0;
    endtask

    task automatic do_reset();
        clr();
        rst = 1;
        cycle();
        rst = 0;
    endtask

    task automatic alloc_fill();
        in_alloc_req = 1; cycle(); in_alloc_req = 0;
        in_fill_done = 1; cycle(); in_fill_done = 0;
    endtask

    // Leaves bank 0 DRAINING, bank 1 SORTING, bank 2 FILLING
    task automatic build_mid();
        alloc_fill();
        alloc_fill();
        srt_await = 1; cycle(); srt_await = 0;
        srt_emit  = 1; cycle(); srt_emit  = 0;
        eg_rdy    = 1; cycle(); eg_rdy    = 0;
        srt_await = 1; cycle(); srt_await = 0;
        check("mid_srt_bank", 32'(srt_bank), 32'd1);
        in_alloc_req = 1; cycle(); in_alloc_req = 0;
    endtask

    initial begin
        clr();
        rst = 1;
        model_reset();
        cycle();
        cycle();
        check("rst_bank_state", 32'(bank_state), 32'd0);
        check("rst_err",        32'(err),        32'd0);
        check("rst_eg_vld",     32'(eg_vld),     32'd0);
        rst = 0;

        // single bank end to end
        in_alloc_req = 1; cycle(); in_alloc_req = 0;
        check("e2e_alloc_gnt", 32'(in_alloc_gnt), 32'd1);
        check("e2e_in_bank",   32'(in_bank),      32'd0);
        in_fill_done = 1; cycle(); in_fill_done = 0;
        srt_await = 1; cycle(); srt_await = 0;
        check("e2e_srt_gnt",  32'(srt_gnt),  32'd1);
        check("e2e_srt_bank", 32'(srt_bank), 32'd0);
        srt_emit = 1; cycle(); srt_emit = 0;
        check("e2e_eg_vld",  32'(eg_vld),  32'd1);
        check("e2e_eg_bank", 32'(eg_bank), 32'd0);
        eg_rdy = 1; cycle(); eg_rdy = 0;
        check("e2e_draining", 32'(bank_state), 32'h005);
        eg_done = 1; cycle(); eg_done = 0;
        check("e2e_all_empty", 32'(bank_state), 32'd0);
        check("e2e_eg_vld_off", 32'(eg_vld), 32'd0);

        // full ring stalls ingress, freed bank regranted two cycles after eg_done
        do_reset();
        for (int b = 0; b < 4; b++) begin
            in_alloc_req = 1; cycle(); in_alloc_req = 0;
            check("full_gnt",  32'(in_alloc_gnt), 32'd1);
            check("full_bank", 32'(in_bank),      32'(b));
            in_fill_done = 1; cycle(); in_fill_done = 0;
        end
        check("full_all_ready", 32'(bank_state), 32'h492);
        in_alloc_req = 1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("full_stall", 32'(in_alloc_gnt), 32'd0);
        end
        srt_await = 1; cycle(); srt_await = 0;
        srt_emit  = 1; cycle(); srt_emit  = 0;
        eg_rdy    = 1; cycle(); eg_rdy    = 0;
        eg_done   = 1; cycle(); eg_done   = 0;
        check("free_t1_gnt", 32'(in_alloc_gnt), 32'd0);
        cycle();
        check("free_t2_gnt",  32'(in_alloc_gnt), 32'd1);
        check("free_t2_bank", 32'(in_bank),      32'd0);
        in_alloc_req = 0;

        // await before any bank is READY
        do_reset();
        in_alloc_req = 1; cycle(); in_alloc_req = 0;
        srt_await = 1; cycle(); srt_await = 0;
        check("early_wait", 32'(srt_gnt), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("early_wait", 32'(srt_gnt), 32'd0);
        end
        in_fill_done = 1; cycle(); in_fill_done = 0;
        check("early_gnt",  32'(srt_gnt),  32'd1);
        check("early_bank", 32'(srt_bank), 32'd0);
`ifdef QS_BANK_SCHED_STATS_EN
        check("early_stall", 32'(stat_stall), 32'd4);
`endif

        // emit, await, eg_done and fill_done in one cycle
        do_reset();
        build_mid();
        check("same_pre", 32'(bank_state), 32'h05D);
        srt_emit = 1; srt_await = 1; eg_done = 1; in_fill_done = 1;
        cycle();
        clr();
        check("same_state", 32'(bank_state), 32'h0E0);
        check("same_gnt",   32'(srt_gnt),    32'd1);
        check("same_bank",  32'(srt_bank),   32'd2);
        check("same_err",   32'(err),        32'd0);

        // emit with nothing SORTING
        do_reset();
        in_alloc_req = 1; cycle(); in_alloc_req = 0;
        srt_emit = 1; cycle(); srt_emit = 0;
        check("perr_err",   32'(err),        32'd1);
        check("perr_state", 32'(bank_state), 32'h001);
        for (int k = 0; k < 4; k++) begin
            cycle();
            check("perr_sticky", 32'(err), 32'd1);
        end
        rst = 1; cycle(); rst = 0;
        check("perr_cleared", 32'(err), 32'd0);

        // reset with SORTING and DRAINING banks outstanding
        do_reset();
        build_mid();
        rst = 1; cycle(); rst = 0;
        check("mrst_in_gnt",   32'(in_alloc_gnt), 32'd0);
        check("mrst_in_bank",  32'(in_bank),      32'd0);
        check("mrst_srt_gnt",  32'(srt_gnt),      32'd0);
        check("mrst_srt_bank", 32'(srt_bank),     32'd0);
        check("mrst_eg_vld",   32'(eg_vld),       32'd0);
        check("mrst_eg_bank",  32'(eg_bank),      32'd0);
        check("mrst_state",    32'(bank_state),   32'd0);
        check("mrst_err",      32'(err),          32'd0);
        in_alloc_req = 1; cycle(); in_alloc_req = 0;
        check("mrst_regrant", 32'(in_alloc_gnt), 32'd1);
        check("mrst_rebank",  32'(in_bank),      32'd0);

        // randomized agents checked against the model every cycle
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            in_alloc_req = 1'($urandom_range(0, 1));
            in_fill_done = (find(m_state, S_FILLING) >= 0) && ($urandom_range(0, 3) == 0);
            srt_emit     = (find(m_state, S_SORTING) >= 0) && ($urandom_range(0, 2) == 0);
            srt_await    = !m_pending && ((find(m_state, S_SORTING) < 0) || srt_emit) &&
                           ($urandom_range(0, 3) == 0);
            eg_rdy       = 1'($urandom_range(0, 1));
            eg_done      = (find(m_state, S_DRAINING) >= 0) && ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 199) == 0) begin
                case ($urandom_range(0, 3))
                    0: in_fill_done = 1;
                    1: srt_emit     = 1;
                    2: eg_done      = 1;
                    default: srt_await = 1;
                endcase
            end
            rst = ($urandom_range(0, 499) == 0);
            cycle();
        end
        clr();
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qs_bank_sched.md
# qs_bank_sched

Bank scheduler for the quicksort engine. Owns the lifecycle of `BANKS_N` data banks and sequences them between three agents: the ingress filler, the sort engine and the egress drainer. The sort engine's `await` instruction is answered by this block granting the next ready bank. Its `emit` instruction retires the currently selected bank to egress. Banks rotate in strict ring order so that output order equals input order.

## Interface
- `BANKS_N`, 4: number of banks. Must be a power of two, ≥2.
- `BANK_W`, `$clog2(BANKS_N)`: bank index width. Derived; do not override.

Ports:
- `clk`  in  1  Clock. Single clock domain; one clock.
- `rst`  in  1  Reset. Synchronous, active-high.
- `in_alloc_req`  in  1  Level. Ingress requests an empty bank.
- `in_alloc_gnt`  out  1  One-cycle pulse. Bank allocated to ingress.
- `in_bank`  out  BANK_W  Bank granted to ingress. Valid with `in_alloc_gnt` and held until the next grant.
- `in_fill_done`  in  1  Pulse. Ingress has finished filling its bank.
- `srt_await`  in  1  Pulse. Sort engine executed `await`.
- `srt_gnt`  out  1  One-cycle pulse. The selected bank is ready to sort.
- `srt_bank`  out  BANK_W  Currently selected bank. Updated with `srt_gnt`.
- `srt_emit`  in  1  Pulse. Sort engine executed `emit`.
- `eg_vld`  out  1  Level. A sorted bank is available to egress.
- `eg_bank`  out  BANK_W  Bank offered to egress.
- `eg_rdy`  in  1  Egress accepts the offered bank.
- `eg_done`  in  1  Pulse. Egress has finished draining its bank.
- `bank_state`  out  3×BANKS_N  Packed per-bank state, for debug.
- `err`  out  1  Sticky protocol-error flag. Cleared only by `rst`.

## Operation
Per-bank state (`bank_state_t`):
- `EMPTY`: 0
- `FILLING`: 1
- `READY`: 2
- `SORTING`: 3
- `SORTED`: 4
- `DRAINING`: 5

Three ring pointers, each `BANK_W` bits, increment modulo `BANKS_N`: `fill_ptr`, `sort_ptr`, `drain_ptr`.

Transitions:
- **Ingress allocation:** when `in_alloc_req`=1, no bank is `FILLING`, and `bank[fill_ptr]`=`EMPTY`:
  - register `in_alloc_gnt`=1 and `in_bank`=`fill_ptr`;
  - bank goes to `FILLING`;
  - `fill_ptr` increments.
- **Fill done:** `in_fill_done` moves the `FILLING` bank to `READY`.
- **Await:** `srt_await` sets a `pending` flag. While `pending`=1, no bank is `SORTING`, and `bank[sort_ptr]`=`READY`:
  - register `srt_gnt`=1 and `srt_bank`=`sort_ptr`;
  - bank goes to `SORTING`;
  - `pending` clears.
- **Emit:** `srt_emit` moves the `SORTING` bank to `SORTED` and increments `sort_ptr`.
- **Egress offer:** `eg_vld` = (`bank[drain_ptr]`==`SORTED`), with `eg_bank`=`drain_ptr`.
  - `eg_vld`&`eg_rdy` moves the bank to `DRAINING`.
  - `eg_done` moves the `DRAINING` bank to `EMPTY` and increments `drain_ptr`.
- **Error cases:** each sets `err` and leaves state unchanged.
  - `in_fill_done` with no `FILLING` bank.
  - `srt_emit` with no `SORTING` bank.
  - `eg_done` with no `DRAINING` bank.
  - `srt_await` while `pending`=1 or a bank is `SORTING`.
- At most one bank per agent is owned at any time. The agents touch distinct banks, so all three agents may transition in the same cycle.

## Timing
- All outputs are registered.
- Reset values: all banks `EMPTY`; pointers 0; `pending`=0; `in_alloc_gnt`, `srt_gnt`, `eg_vld`, `err` = 0; `in_bank`, `srt_bank`, `eg_bank` = 0.
- All decisions use the current-cycle state. A bank freed in cycle T becomes grantable in cycle T+1, and its grant pulse appears at T+2.
- **Await latency:** when a bank is already `READY`, `srt_await` in cycle T gives `srt_gnt` in T+1. Otherwise `srt_gnt` follows one cycle after the bank becomes `READY`.
- **Emit and await in the same cycle:** the emit retires first, and the await stays pending. The grant appears no earlier than T+1, and only if the next bank is `READY`.
- **`in_alloc_req` held high:** grants are at most one per fill. The next grant is possible one cycle after `in_fill_done` is seen.
- **Full ring:** all banks non-`EMPTY`. Ingress stalls with no grant, and `in_alloc_req` is simply held.
- **Empty ring:** `eg_vld`=0, and `pending` waits indefinitely.
- **`rst` asserted mid-operation:** all ownership is abandoned at the next edge, and a pending await is dropped. Agents must re-request.

## Configuration
- `QS_BANK_SCHED_STATS_EN` defined: adds two output ports.
  - `stat_sorts` (16 bits): saturating count of accepted `srt_emit`.
  - `stat_stall` (16 bits): saturating count of cycles with `pending`=1 and no grant.
  - Both reset to 0.
- Undefined: these ports and their counters are absent, and behaviour is otherwise identical.

## Structure
- `qs_srt_pkg` gains:
  - `bank_state_t`;
  - `BANKS_N_DEFAULT`=4;
  - `bank_id_t` typedef.
- One sub-module, `qs_bank_sched_ptr`: a modulo-`BANKS_N` ring pointer with `inc` and `rst` inputs, instantiated three times.
- Remaining logic is flat: the bank-state array, `pending`, `err`, and the optional stats.

## Test plan
- **Reset, then a single bank end to end:**
  - `in_alloc_req` at cycle 1 → `in_alloc_gnt` and `in_bank`=0 at cycle 2.
  - `in_fill_done` → `srt_await` → `srt_gnt` and `srt_bank`=0 one cycle later.
  - `srt_emit` → `eg_vld` and `eg_bank`=0.
  - `eg_rdy`, then `eg_done` → `bank_state` all `EMPTY`.
- **Fill all 4 banks without draining:** 5th `in_alloc_req` gets no grant. After `eg_done` on bank 0, the grant arrives two cycles later with `in_bank`=0.
- **`srt_await` issued before any bank is `READY`:** `srt_gnt` fires exactly one cycle after `in_fill_done`. With stats enabled, `stat_stall` equals the number of waiting cycles.
- **Same-cycle events:** `srt_emit` on bank 1, `srt_await`, `eg_done` on bank 0 and `in_fill_done` on bank 2, all in one cycle → next cycle shows bank 1 `SORTED`, bank 0 `EMPTY`, and `srt_gnt` with `srt_bank`=2.
- **Protocol errors:** `srt_emit` with no `SORTING` bank → `err`=1 and remains 1 until `rst`, with `bank_state` unchanged.
- **`rst` while banks are `SORTING` and `DRAINING`:** all outputs return to 0 next cycle. A subsequent allocation grants bank 0.
